// File: rtl/video_mode_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// video_mode_pkg
// Shared definitions for the video mode switching controller.
//   state_t       : controller FSM states
//   MODE_640X480  : mode select value for the 640x480@60 timing set
//   MODE_800X600  : mode select value for the 800x600@72 timing set
// -----------------------------------------------------------------------------
package video_mode_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        SWITCH     = 2'd2,
        SETTLE     = 2'd3
    } state_t;

    localparam logic MODE_640X480 = 1'b0;
    localparam logic MODE_800X600 = 1'b1;

endpackage

// File: rtl/video_mode_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// mode_req_debounce
// Brings the raw board switch level into the clock domain and only accepts a
// new level after it has been stable for DEBOUNCE_CYCLES consecutive cycles.
//   clock      in  : system/pixel clock
//   reset      in  : asynchronous, active-high reset
//   mode_req   in  : raw switch level, asynchronous to clock
//   req_stable out : debounced request level
// -----------------------------------------------------------------------------
module mode_req_debounce #(
    parameter int   DEBOUNCE_CYCLES = 1000000,
    parameter int   CNT_W           = 24,
    parameter logic RESET_MODE      = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic mode_req,
    output logic req_stable
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_reqStable;
    logic [CNT_W-1:0] r_cnt;

    // Two-flop synchroniser; the flops reset to the reset mode so that an
    // idle switch at the reset level does not look like a request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= RESET_MODE;
            r_sync2 <= RESET_MODE;
        end else begin
            r_sync1 <= mode_req;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive cycles that the synchronised level disagrees with the
    // accepted level; any agreeing cycle restarts the count, so bounce never
    // accumulates towards acceptance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_reqStable <= RESET_MODE;
            r_cnt       <= '0;
        end else if (r_sync2 == r_reqStable) begin
            r_cnt <= '0;
        end else if (r_cnt == DB_LAST) begin
            r_reqStable <= r_sync2;
            r_cnt       <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign req_stable = r_reqStable;

endmodule

// File: rtl/video_mode_ctrl.sv
// -----------------------------------------------------------------------------
// video_mode_ctrl
// Sequences a safe run-time switch between the 640x480@60 and 800x600@72
// timing sets: blank the display, change mode only at a frame boundary, then
// hold blank for SETTLE_FRAMES whole frames before handing the display back.
//   clock        in  : system/pixel clock
//   reset        in  : asynchronous, active-high reset
//   mode_req     in  : raw switch level, asynchronous to clock
//   ypos         in  : current vertical position from the sync multiplexer
//   mode         out : registered mode select to the sync multiplexer
//   blank        out : registered; 1 forces pixel output black
//   busy         out : registered; 1 whenever a switch sequence is in flight
//   mode_changed out : one-cycle pulse in the cycle mode takes its new value
// -----------------------------------------------------------------------------
module video_mode_ctrl
    import video_mode_pkg::*;
#(
    parameter logic RESET_MODE      = MODE_800X600,
    parameter int   DEBOUNCE_CYCLES = 1000000,
    parameter int   FRAME_TIMEOUT   = 2000000,
    parameter int   SETTLE_FRAMES   = 2,
    parameter int   CNT_W           = 24
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mode_req,
    input  logic [10:0] ypos,
    output logic        mode,
    output logic        blank,
    output logic        busy,
    output logic        mode_changed
);

    localparam int               FC_W       = $clog2(SETTLE_FRAMES + 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(FRAME_TIMEOUT - 1);
    localparam logic [FC_W-1:0]  FRAME_LAST = FC_W'(SETTLE_FRAMES - 1);

    logic             w_reqStable;
    logic             w_fb;
    logic             w_frameEvent;

    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic [FC_W-1:0]  r_frames;
    logic [FC_W-1:0]  w_framesNext;
    logic             r_target;
    logic             w_targetNext;
    logic             r_mode;
    logic             w_modeNext;
    logic             r_blank;
    logic             w_blankNext;
    logic             r_busy;
    logic             w_busyNext;
    logic             r_changed;
    logic             w_changedNext;
    logic [10:0]      r_yposPrev;

    mode_req_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .RESET_MODE      (RESET_MODE)
    ) u_debounce (
        .clock      (clock),
        .reset      (reset),
        .mode_req   (mode_req),
        .req_stable (w_reqStable)
    );

    // A frame boundary is ypos wrapping back to zero. A stuck-at-zero ypos
    // never qualifies, which is why the cycle timeout stands in for it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_yposPrev <= '0;
        end else begin
            r_yposPrev <= ypos;
        end
    end

    assign w_fb         = (r_yposPrev != 11'd0) && (ypos == 11'd0);
    assign w_frameEvent = w_fb || (r_cnt == TO_LAST);

    // Reset lands in SETTLE so the display stays blank for whole frames of
    // the reset timing before anything is shown.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= SETTLE;
            r_cnt     <= '0;
            r_frames  <= '0;
            r_target  <= RESET_MODE;
            r_mode    <= RESET_MODE;
            r_blank   <= 1'b1;
            r_busy    <= 1'b1;
            r_changed <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_frames  <= w_framesNext;
            r_target  <= w_targetNext;
            r_mode    <= w_modeNext;
            r_blank   <= w_blankNext;
            r_busy    <= w_busyNext;
            r_changed <= w_changedNext;
        end
    end

    // Next-state and registered-output logic. The target is latched once on
    // leaving IDLE, so request changes during a sequence are picked up only
    // when IDLE is reached again.
    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        w_framesNext  = r_frames;
        w_targetNext  = r_target;
        w_modeNext    = r_mode;
        w_blankNext   = r_blank;
        w_busyNext    = r_busy;
        w_changedNext = 1'b0;

        case (r_state)
            IDLE: begin
                w_blankNext = 1'b0;
                w_busyNext  = 1'b0;
                w_cntNext   = '0;
                if (w_reqStable != r_mode) begin
                    w_targetNext = w_reqStable;
                    w_blankNext  = 1'b1;
                    w_busyNext   = 1'b1;
                    w_stateNext  = WAIT_FRAME;
                end
            end

            WAIT_FRAME: begin
                if (w_frameEvent) begin
                    w_cntNext   = '0;
                    w_stateNext = SWITCH;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end

            SWITCH: begin
                w_modeNext    = r_target;
                w_changedNext = 1'b1;
                w_framesNext  = '0;
                w_cntNext     = '0;
                w_stateNext   = SETTLE;
            end

            SETTLE: begin
                w_blankNext = 1'b1;
                w_busyNext  = 1'b1;
                if (w_frameEvent) begin
                    w_cntNext = '0;
                    if (r_frames == FRAME_LAST) begin
                        w_framesNext = '0;
                        w_blankNext  = 1'b0;
                        w_busyNext   = 1'b0;
                        w_stateNext  = IDLE;
                    end else begin
                        w_framesNext = r_frames + FC_W'(1);
                    end
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign mode         = r_mode;
    assign blank        = r_blank;
    assign busy         = r_busy;
    assign mode_changed = r_changed;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_video_mode_ctrl
// Self-checking bench for video_mode_ctrl. A reference model tracks what the
// display should be doing and queues expected switch/release events; a monitor
// compares the DUT against it every cycle and pops events as they appear.
// -----------------------------------------------------------------------------
module tb_video_mode_ctrl;

    localparam int DB = 4;
    localparam int FT = 100;
    localparam int SF = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        mode_req;
    logic [10:0] ypos;
    logic        mode;
    logic        blank;
    logic        busy;
    logic        mode_changed;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int   kind;
        logic modeVal;
        int   cyc;
    } event_t;

    event_t expQ[$];
    int     cycleNo = 0;
    int     dutPulses = 0;

    logic   yHold = 1'b0;
    int     frameLen = 10;

    always #5 clock = ~clock;

    video_mode_ctrl #(
        .RESET_MODE      (1'b1),
        .DEBOUNCE_CYCLES (DB),
        .FRAME_TIMEOUT   (FT),
        .SETTLE_FRAMES   (SF),
        .CNT_W           (24)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mode_req     (mode_req),
        .ypos         (ypos),
        .mode         (mode),
        .blank        (blank),
        .busy         (busy),
        .mode_changed (mode_changed)
    );

    // Record one comparison and report it if it does not hold.
    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive the request level and let a number of cycles pass.
    task automatic applyStimulus(input logic req, input int cycles);
        mode_req = req;
        repeat (cycles) @(negedge clock);
    endtask

    // Vertical position source: counts 0..frameLen-1 or sits at zero.
    initial begin
        ypos = '0;
        forever begin
            @(negedge clock);
            if (yHold) ypos = '0;
            else       ypos = 11'((int'(ypos) + 1) % frameLen);
        end
    end

    // Reference model: what the display should be showing, in terms of a
    // pending request, the boundary being waited for and frames left to hold.
    logic mMode, mBlank, mBusy, mPulse, mTarget;
    logic mWaiting, mSwitchNext, mSettling;
    int   mFramesSeen, mCycles;
    logic mS1, mS2, mStable;
    logic mHist[$];
    int   mPrevY;

    always @(posedge clock or posedge reset) begin
        logic   ev;
        logic   allDiffer;
        event_t e;
        if (reset) begin
            mMode = 1'b1; mBlank = 1'b1; mBusy = 1'b1; mPulse = 1'b0; mTarget = 1'b1;
            mWaiting = 1'b0; mSwitchNext = 1'b0; mSettling = 1'b1;
            mFramesSeen = 0; mCycles = 0;
            mS1 = 1'b1; mS2 = 1'b1; mStable = 1'b1;
            mHist.delete();
            mPrevY = 0;
            expQ.delete();
        end else begin
            cycleNo++;
            ev = ((mPrevY != 0) && (ypos == 0)) || (mCycles == FT - 1);
            mPulse = 1'b0;
            if (mSettling) begin
                if (ev) begin
                    mCycles = 0;
                    mFramesSeen++;
                    if (mFramesSeen == SF) begin
                        mSettling = 1'b0;
                        mFramesSeen = 0;
                        mBlank = 1'b0;
                        mBusy = 1'b0;
                        e.kind = 1; e.modeVal = mMode; e.cyc = cycleNo;
                        expQ.push_back(e);
                    end
                end else begin
                    mCycles++;
                end
            end else if (mSwitchNext) begin
                mMode = mTarget;
                mPulse = 1'b1;
                mSwitchNext = 1'b0;
                mSettling = 1'b1;
                mFramesSeen = 0;
                mCycles = 0;
                e.kind = 0; e.modeVal = mMode; e.cyc = cycleNo;
                expQ.push_back(e);
            end else if (mWaiting) begin
                if (ev) begin
                    mWaiting = 1'b0;
                    mSwitchNext = 1'b1;
                    mCycles = 0;
                end else begin
                    mCycles++;
                end
            end else if (mStable != mMode) begin
                mTarget = mStable;
                mBlank = 1'b1;
                mBusy = 1'b1;
                mCycles = 0;
                mWaiting = 1'b1;
            end
            // A request is accepted once the last DB synchronised samples all
            // disagree with the currently accepted level.
            mHist.push_back(mS2);
            if (mHist.size() > DB) void'(mHist.pop_front());
            allDiffer = (mHist.size() == DB);
            foreach (mHist[i]) if (mHist[i] == mStable) allDiffer = 1'b0;
            if (allDiffer) mStable = mS2;
            mS2 = mS1;
            mS1 = mode_req;
            mPrevY = int'(ypos);
        end
    end

    // Monitor: per-cycle comparison plus scoreboard popping on DUT events.
    logic lastBusy = 1'b1;
    always @(negedge clock) begin
        event_t e;
        checkOutput("mode", int'(mode), int'(mMode));
        checkOutput("blank", int'(blank), int'(mBlank));
        checkOutput("busy", int'(busy), int'(mBusy));
        checkOutput("mode_changed", int'(mode_changed), int'(mPulse));
        if (mode_changed) begin
            dutPulses++;
            checkOutput("switch_expected", int'(expQ.size() > 0), 1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("switch_kind", 0, e.kind);
                checkOutput("switch_mode", int'(mode), int'(e.modeVal));
                checkOutput("switch_cycle", cycleNo, e.cyc);
            end
        end
        if (lastBusy && !busy) begin
            checkOutput("release_expected", int'(expQ.size() > 0), 1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("release_kind", 1, e.kind);
                checkOutput("release_mode", int'(mode), int'(e.modeVal));
                checkOutput("release_cycle", cycleNo, e.cyc);
            end
        end
        lastBusy = busy;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int startPulses;
        int lowCycles;
        logic sawBusy;

        // Reset with ypos cycling 0..9.
        reset = 1'b1;
        mode_req = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("reset_mode", int'(mode), 1);
        checkOutput("reset_blank", int'(blank), 1);
        checkOutput("reset_busy", int'(busy), 1);
        checkOutput("reset_mode_changed", int'(mode_changed), 0);
        #2 reset = 1'b0;
        applyStimulus(1'b1, 40);
        checkOutput("boot_blank", int'(blank), 0);
        checkOutput("boot_busy", int'(busy), 0);
        checkOutput("boot_mode", int'(mode), 1);
        checkOutput("boot_pulses", dutPulses, 0);

        // Request 640x480: blanking starts 7 cycles after the drive.
        mode_req = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        checkOutput("req0_busy_latency", n, 7);
        checkOutput("req0_blank", int'(blank), 1);
        n = 0;
        while (mode_changed !== 1'b1 && n < 40) begin @(negedge clock); n++; end
        checkOutput("req0_switched", int'(mode_changed), 1);
        checkOutput("req0_mode", int'(mode), 0);
        n = 0;
        while (busy !== 1'b0 && n < 60) begin @(negedge clock); n++; end
        checkOutput("req0_released", int'(busy), 0);
        checkOutput("req0_blank_off", int'(blank), 0);

        // Back to 800x600, then chatter that must be ignored.
        applyStimulus(1'b1, 80);
        checkOutput("req1_mode", int'(mode), 1);
        sawBusy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            mode_req = ~mode_req;
            repeat (2) begin
                @(negedge clock);
                if (busy) sawBusy = 1'b1;
            end
        end
        applyStimulus(mode_req, 10);
        checkOutput("bounce_final_level", int'(mode_req), 1);
        checkOutput("bounce_no_busy", int'(sawBusy), 0);
        checkOutput("bounce_mode", int'(mode), 1);

        // Dead sync: ypos stuck at zero, timeouts carry the sequence.
        yHold = 1'b1;
        applyStimulus(1'b1, 5);
        startPulses = dutPulses;
        mode_req = 1'b0;
        n = 0;
        while (mode_changed !== 1'b1 && n < 200) begin @(negedge clock); n++; end
        checkOutput("dead_switch_latency", n, 108);
        checkOutput("dead_mode", int'(mode), 0);
        while (busy !== 1'b0 && n < 500) begin @(negedge clock); n++; end
        checkOutput("dead_release_latency", n, 308);
        checkOutput("dead_blank", int'(blank), 0);
        checkOutput("dead_pulses", dutPulses - startPulses, 1);
        yHold = 1'b0;

        // Request reversed during SETTLE: two full sequences.
        applyStimulus(1'b1, 80);
        checkOutput("rev_start_mode", int'(mode), 1);
        startPulses = dutPulses;
        mode_req = 1'b0;
        n = 0;
        while (mode_changed !== 1'b1 && n < 60) begin @(negedge clock); n++; end
        mode_req = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 80) begin @(negedge clock); n++; end
        checkOutput("rev_first_mode", int'(mode), 0);
        lowCycles = 0;
        while (busy === 1'b0 && lowCycles < 20) begin @(negedge clock); lowCycles++; end
        checkOutput("rev_idle_cycles", lowCycles, 1);
        n = 0;
        while (busy !== 1'b0 && n < 80) begin @(negedge clock); n++; end
        applyStimulus(1'b1, 5);
        checkOutput("rev_final_mode", int'(mode), 1);
        checkOutput("rev_pulses", dutPulses - startPulses, 2);

        // Reset in the middle of WAIT_FRAME discards the target.
        mode_req = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        mode_req = 1'b1;
        #1;
        checkOutput("midrst_mode", int'(mode), 1);
        checkOutput("midrst_blank", int'(blank), 1);
        checkOutput("midrst_busy", int'(busy), 1);
        checkOutput("midrst_mode_changed", int'(mode_changed), 0);
        @(negedge clock);
        #2 reset = 1'b0;
        startPulses = dutPulses;
        applyStimulus(1'b1, 60);
        checkOutput("midrst_no_switch", dutPulses - startPulses, 0);
        checkOutput("midrst_idle", int'(busy), 0);

        // Randomised requests, frame lengths and dead-sync stretches.
        for (int i = 0; i < 30; i++) begin
            frameLen = int'($urandom_range(16, 4));
            yHold = ($urandom_range(7, 0) == 0);
            applyStimulus(1'($urandom_range(1, 0)), int'($urandom_range(40, 1)));
        end
        yHold = 1'b0;
        frameLen = 10;
        applyStimulus(mode_req, 500);
        checkOutput("final_mode_follows_req", int'(mode), int'(mode_req));
        checkOutput("final_queue_empty", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/video_mode_ctrl.md
Name: video_mode_ctrl

Overview:
- Sequences safe run-time switching between the 640x480@60 and 800x600@72 timing sets by driving the `mode` select of the sync multiplexer.
- Synchronises and debounces a board switch request.
- Forces the display blank, then changes mode only at a frame boundary.
- Keeps blanking for a settle period of whole frames before releasing the display to the pixel pipeline.

Parameters:
- RESET_MODE, 1, mode value after reset (0 = 640x480, 1 = 800x600).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a request change.
- FRAME_TIMEOUT, 2000000, cycles without a frame boundary before a boundary is assumed by the FSM (dead-sync guard).
- SETTLE_FRAMES, 2, frame boundaries counted after a switch before unblanking (>=1).
- CNT_W, 24, width of the shared cycle counter; must hold max(DEBOUNCE_CYCLES, FRAME_TIMEOUT).

Ports:
- clock  input  1  system/pixel clock.
- reset  input  1  asynchronous, active-high reset.
- mode_req  input  1  raw switch level, asynchronous to clock.
- ypos  input  11  current vertical position from the sync multiplexer.
- mode  output  1  registered mode select to the sync multiplexer.
- blank  output  1  registered; 1 forces pixel output black.
- busy  output  1  registered; 1 whenever the FSM is not in IDLE.
- mode_changed  output  1  one-cycle pulse in the cycle `mode` takes its new value.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high, and acts on all flops.
- Reset values:
  - mode=RESET_MODE, blank=1, busy=1, mode_changed=0.
  - FSM state=SETTLE with frame count 0 and cycle count 0.
  - ypos_prev=0, synchroniser flops=RESET_MODE, req_stable=RESET_MODE.
- Request path (sub-module):
  - Two-flop synchroniser produces req_s.
  - The cycle counter clears whenever req_s==req_stable.
  - It increments while req_s!=req_stable.
  - When it reaches DEBOUNCE_CYCLES-1 with req_s still differing, req_stable<=req_s and the counter clears.
  - Latency from a clean mode_req edge to a req_stable change is 2+DEBOUNCE_CYCLES cycles.
- Frame boundary (fb): ypos_prev!=0 && ypos==0, with ypos_prev registered every cycle. A constant-zero ypos never produces fb.
- FSM:
  - IDLE: blank=0, busy=0. If req_stable!=mode, latch target<=req_stable, set blank<=1, clear the cycle counter and go to WAIT_FRAME.
  - WAIT_FRAME: the cycle counter increments each cycle. On fb, or when the counter reaches FRAME_TIMEOUT-1, go to SWITCH.
  - SWITCH (exactly 1 cycle): mode<=target, mode_changed<=1, frame count<=0, cycle counter<=0, go to SETTLE.
  - SETTLE:
    - blank=1.
    - On fb, or when the cycle counter reaches FRAME_TIMEOUT-1: frame count +1 and cycle counter cleared.
    - When frame count reaches SETTLE_FRAMES, go to IDLE with blank<=0 and busy<=0 registered in the same edge.
- Simultaneous and boundary events:
  - Request changes during WAIT_FRAME, SWITCH or SETTLE do not alter target. They are re-evaluated in IDLE, so the final settled request is always honoured; a change back during WAIT_FRAME still completes one switch and then another.
  - fb and timeout in the same cycle count as one event.
  - If req_stable==mode on entry to IDLE, the FSM stays in IDLE.
  - Reset mid-operation returns to the reset state; the in-flight target is discarded.
- The sync multiplexer adds one cycle of registration, so the first fb in SETTLE is from the new timing.
- Frame count width is clog2(SETTLE_FRAMES+1). All counters are unsigned and never wrap: they are cleared at their terminal value.

Decomposition:
- Package video_mode_pkg:
  - state enum IDLE/WAIT_FRAME/SWITCH/SETTLE;
  - constants MODE_640X480=1'b0, MODE_800X600=1'b1.
- Sub-module mode_req_debounce:
  - contains the synchroniser and debounce counter;
  - parameters DEBOUNCE_CYCLES, CNT_W, RESET_MODE;
  - ports clock, reset, mode_req, req_stable.
- The FSM, fb detector and settle counters stay in video_mode_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, FRAME_TIMEOUT=100, SETTLE_FRAMES=2, RESET_MODE=1):
- Reset release with ypos cycling 0..9 -> blank=1 and busy=1 until the 2nd fb, then blank=0, busy=0, mode=1, no mode_changed pulse.
- mode_req 1->0 held -> req_stable falls 6 cycles later.
  - Next cycle: blank=1, busy=1.
  - mode=0 with a 1-cycle mode_changed, 1 cycle after the next ypos 9->0.
  - blank=0 after 2 further fbs.
- mode_req toggles every 2 cycles for 40 cycles, ending at 1 -> req_stable stays 1, busy stays 0, mode stays 1.
- ypos held at 0 after a request to mode 0 -> SWITCH after 100 cycles in WAIT_FRAME; settle completes via two 100-cycle timeouts; blank=0.
- Request 0 accepted, then mode_req returns to 1 during SETTLE -> mode=0 completes, IDLE for 1 cycle, then a second sequence ends with mode=1; exactly 2 mode_changed pulses.
- reset asserted mid-WAIT_FRAME -> outputs immediately return to reset values, mode=1, and no switch occurs.
